batcharger_ctrl: RTL and testbench
==================================

# batcharger_ctrl

Digital charge controller that sits directly upstream of the battery charger analog core. It consumes ADC samples of battery voltage, charge current and temperature, and runs the trickle / constant-current / constant-voltage charge sequence. It drives the core's mode selects and current-reference DAC code, and flags end-of-charge and temperature or timeout faults.

## Interface

Parameters:
- VTC, 8'd150: vbat code below which trickle charge is used.
- VCV, 8'd200: vbat code at which CC hands over to CV.
- VRCH, 8'd190: vbat code below which DONE restarts charging.
- ITERM, 8'd10: ibat code below which CV terminates.
- TEMP_MAX, 8'd100: vtemp code above which charging stops (over-temperature).
- TEMP_HYST, 8'd8: vtemp hysteresis required to leave FAULT.
- TC_TIMEOUT, 16'd500: maximum valid samples allowed in TC.
- CV_TIMEOUT, 16'd1000: maximum valid samples allowed in CV.

Ports:
- clk, in, 1: single clock.
- rstz, in, 1: reset; synchronous, active-low.
- en, in, 1: charger enable.
- sel, in, 4: battery capacity select. Sets the CC current.
- adc_valid, in, 1: one-cycle strobe that marks vbat/ibat/vtemp as a new sample.
- vbat, in, 8: battery voltage ADC code.
- ibat, in, 8: charge current ADC code.
- vtemp, in, 8: temperature ADC code. Larger code means hotter.
- tc, out, 1: trickle mode select to the core.
- cc, out, 1: constant-current mode select to the core.
- cv, out, 1: constant-voltage mode select to the core.
- iref, out, 8: current reference DAC code.
- done, out, 1: charge complete.
- fault, out, 1: over-temperature or timeout fault.
- state, out, 3: current FSM state, for debug.

## Operation

- State encoding: IDLE=0, TC=1, CC=2, CV=3, DONE=4, FAULT=5. Codes 6 and 7 are illegal and go to IDLE on the next clock.
- Output decode from state:
  - tc=(TC), cc=(CC), cv=(CV), done=(DONE), fault=(FAULT).
  - icc={sel,4'b0000}.
  - iref: icc in CC and CV; icc>>3 in TC; 0 in all other states.
- Priority, highest first:
  1. rstz=0.
  2. en=0: go to IDLE on the next clock, evaluated every cycle regardless of adc_valid.
  3. Temperature fault.
  4. Phase transitions.
- All other transitions are evaluated only on cycles where adc_valid=1, using that cycle's inputs.
- IDLE, with en=1 and sel!=0:
  - vtemp>TEMP_MAX goes to FAULT.
  - else vbat<VTC goes to TC.
  - else vbat<VCV goes to CC.
  - else goes to CV.
  - With sel=0, IDLE holds.
- Temperature fault: from TC, CC or CV, vtemp>TEMP_MAX goes to FAULT.
- TC:
  - vbat>=VTC goes to CC.
  - tc_cnt reaching TC_TIMEOUT goes to FAULT.
- CC: vbat>=VCV goes to CV.
- CV:
  - ibat<ITERM on 4 consecutive valid samples goes to DONE. A sample with ibat>=ITERM clears term_cnt.
  - cv_cnt reaching CV_TIMEOUT goes to DONE.
- DONE: vbat<VRCH goes to CC if vbat>=VTC, else to TC.
- FAULT:
  - vtemp<=TEMP_MAX-TEMP_HYST goes to IDLE.
  - A timeout fault is left only via en=0 or reset. Track it with a sticky tmo_flag, cleared in IDLE.
- Counters:
  - tc_cnt and cv_cnt are 16 bit. They increment on adc_valid in their own state only and saturate.
  - term_cnt is 2 bit.
  - All three clear on any state change.
- sel is sampled continuously. A sel change during CC or CV updates iref on the next clock.

## Timing

- Reset: rstz low at a clk edge gives state=IDLE, all outputs 0 (iref=0) and all counters 0 after that edge. Mid-charge reset behaves identically.
- Latency:
  - adc_valid sample to new state and outputs: 1 clock.
  - en falling to IDLE with iref=0: 1 clock.
- Outputs are registered and glitch-free; tc, cc, cv and done are mutually exclusive.
- Simultaneous events:
  - en=0 together with a fault: IDLE wins.
  - Over-temperature together with vbat>=VCV in CC: FAULT wins.
  - Termination and timeout on the same sample: DONE.
- Back-to-back adc_valid on every cycle is legal. Every strobe counts.

## Test plan

- Reset, then en=1, sel=4'b1010, vbat=120, vtemp=50, one adc_valid -> next cycle state=TC, tc=1, iref=20. Then vbat=160 -> CC, iref=160.
- CC with vbat=205 -> CV, cv=1, iref=160. Then ibat=5 on 4 valid samples -> done=1, iref=0. A 3-then-1 pattern (ibat=5,5,5,20) must not terminate.
- DONE, vbat=185 -> CC. In CC, vtemp=101 -> FAULT, iref=0. vtemp=95 keeps FAULT; vtemp=92 -> IDLE.
- TC with vbat held at 100 for 500 valid samples -> FAULT. vtemp is cool, so FAULT holds until en=0, which gives IDLE.
- CV with ibat=50 for 1000 valid samples -> DONE. A mid-charge en=0 gives IDLE and iref=0 one clock later. rstz=0 in CC gives all outputs 0 at the next edge.
- sel=0 with en=1 and valid samples -> stays IDLE, iref=0.

Source files
------------

// File: rtl/batcharger_ctrl.sv
// Battery charge controller: trickle / constant-current / constant-voltage
// sequencing with temperature and timeout protection. All outputs are
// registered from the next-state decode so they change only on clk.
`timescale 1ns/1ps
module batcharger_ctrl #(
  parameter logic [7:0]  VTC        = 8'd150,
  parameter logic [7:0]  VCV        = 8'd200,
  parameter logic [7:0]  VRCH       = 8'd190,
  parameter logic [7:0]  ITERM      = 8'd10,
  parameter logic [7:0]  TEMP_MAX   = 8'd100,
  parameter logic [7:0]  TEMP_HYST  = 8'd8,
  parameter logic [15:0] TC_TIMEOUT = 16'd500,
  parameter logic [15:0] CV_TIMEOUT = 16'd1000
) (
  input  logic       clk,
  input  logic       rstz,
  input  logic       en,
  input  logic [3:0] sel,
  input  logic       adc_valid,
  input  logic [7:0] vbat,
  input  logic [7:0] ibat,
  input  logic [7:0] vtemp,
  output logic       tc,
  output logic       cc,
  output logic       cv,
  output logic [7:0] iref,
  output logic       done,
  output logic       fault,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_TC    = 3'd1,
    S_CC    = 3'd2,
    S_CV    = 3'd3,
    S_DONE  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  localparam logic [7:0] TEMP_OK = TEMP_MAX - TEMP_HYST;

  state_t      state_q, state_nxt;
  logic [15:0] tc_cnt, tc_cnt_nxt, tc_inc;
  logic [15:0] cv_cnt, cv_cnt_nxt, cv_inc;
  logic [1:0]  term_cnt, term_cnt_nxt;
  logic        tmo_flag, tmo_flag_nxt;
  logic        hot, low_i;
  logic [7:0]  icc, iref_nxt;

  // Saturating increment so the sample counters never wrap.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign hot   = (vtemp > TEMP_MAX);
  assign low_i = (ibat < ITERM);
  assign icc   = {sel, 4'b0000};

  // Next-state, counter and sticky-flag logic; en and illegal codes override sampling.
  always_comb begin
    state_nxt    = state_q;
    tc_inc       = sat_inc16(tc_cnt);
    cv_inc       = sat_inc16(cv_cnt);
    tc_cnt_nxt   = tc_cnt;
    cv_cnt_nxt   = cv_cnt;
    term_cnt_nxt = term_cnt;
    tmo_flag_nxt = tmo_flag;
    if (!en || (state_q > S_FAULT)) begin
      state_nxt = S_IDLE;
    end else if (adc_valid) begin
      case (state_q)
        S_IDLE: begin
          if (sel != 4'd0) begin
            if (hot)              state_nxt = S_FAULT;
            else if (vbat < VTC)  state_nxt = S_TC;
            else if (vbat < VCV)  state_nxt = S_CC;
            else                  state_nxt = S_CV;
          end
        end
        S_TC: begin
          tc_cnt_nxt = tc_inc;
          if (hot)                          state_nxt = S_FAULT;
          else if (vbat >= VTC)             state_nxt = S_CC;
          else if (tc_inc >= TC_TIMEOUT) begin
            state_nxt    = S_FAULT;
            tmo_flag_nxt = 1'b1;
          end
        end
        S_CC: begin
          if (hot)               state_nxt = S_FAULT;
          else if (vbat >= VCV)  state_nxt = S_CV;
        end
        S_CV: begin
          cv_cnt_nxt   = cv_inc;
          term_cnt_nxt = low_i ? term_cnt + 2'd1 : 2'd0;
          if (hot)
            state_nxt = S_FAULT;
          else if ((low_i && (term_cnt == 2'd3)) || (cv_inc >= CV_TIMEOUT))
            state_nxt = S_DONE;
        end
        S_DONE: begin
          if (vbat < VRCH) state_nxt = (vbat >= VTC) ? S_CC : S_TC;
        end
        S_FAULT: begin
          if (!tmo_flag && (vtemp <= TEMP_OK)) state_nxt = S_IDLE;
        end
        default: state_nxt = S_IDLE;
      endcase
    end
    if (state_nxt != state_q) begin
      tc_cnt_nxt   = 16'd0;
      cv_cnt_nxt   = 16'd0;
      term_cnt_nxt = 2'd0;
    end
    if (state_nxt == S_IDLE) tmo_flag_nxt = 1'b0;
  end

  // Current reference for the state being entered, using the live sel value.
  always_comb begin
    iref_nxt = 8'd0;
    case (state_nxt)
      S_TC:       iref_nxt = icc >> 3;
      S_CC, S_CV: iref_nxt = icc;
      default:    iref_nxt = 8'd0;
    endcase
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk) begin
    if (!rstz) begin
      state_q  <= S_IDLE;
      tc_cnt   <= 16'd0;
      cv_cnt   <= 16'd0;
      term_cnt <= 2'd0;
      tmo_flag <= 1'b0;
      tc       <= 1'b0;
      cc       <= 1'b0;
      cv       <= 1'b0;
      done     <= 1'b0;
      fault    <= 1'b0;
      iref     <= 8'd0;
    end else begin
      state_q  <= state_nxt;
      tc_cnt   <= tc_cnt_nxt;
      cv_cnt   <= cv_cnt_nxt;
      term_cnt <= term_cnt_nxt;
      tmo_flag <= tmo_flag_nxt;
      tc       <= (state_nxt == S_TC);
      cc       <= (state_nxt == S_CC);
      cv       <= (state_nxt == S_CV);
      done     <= (state_nxt == S_DONE);
      fault    <= (state_nxt == S_FAULT);
      iref     <= iref_nxt;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_batcharger_ctrl.sv
// Self-checking bench for batcharger_ctrl: directed charge scenarios plus
// randomized traffic, compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_batcharger_ctrl;

  logic       clk = 1'b0;
  logic       rstz, en, adc_valid;
  logic [3:0] sel;
  logic [7:0] vbat, ibat, vtemp;
  logic       tc, cc, cv, done, fault;
  logic [7:0] iref;
  logic [2:0] state;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  // Behavioural model: phase number, samples seen in current phase,
  // run length of low-current samples, timeout latch, sel seen at the edge.
  int m_st   = 0;
  int m_nsmp = 0;
  int m_low  = 0;
  bit m_tmo  = 1'b0;
  int m_sel  = 0;

  batcharger_ctrl dut (
    .clk(clk), .rstz(rstz), .en(en), .sel(sel), .adc_valid(adc_valid),
    .vbat(vbat), .ibat(ibat), .vtemp(vtemp),
    .tc(tc), .cc(cc), .cv(cv), .iref(iref), .done(done), .fault(fault),
    .state(state)
  );

  always #5 clk = ~clk;

  // Model update on each active edge from the inputs held across it.
  always @(posedge clk) begin
    int nxt;
    bit hot;
    nxt = m_st;
    hot = (int'(vtemp) > 100);
    if (!rstz) begin
      nxt = 0;
    end else if (!en) begin
      nxt = 0;
    end else if (adc_valid) begin
      m_nsmp = m_nsmp + 1;
      m_low  = (int'(ibat) < 10) ? m_low + 1 : 0;
      if (m_st == 0) begin
        if (sel != 0) nxt = hot ? 5 : (vbat < 150) ? 1 : (vbat < 200) ? 2 : 3;
      end else if (m_st >= 1 && m_st <= 3 && hot) begin
        nxt = 5;
      end else if (m_st == 1) begin
        if (vbat >= 150) nxt = 2;
        else if (m_nsmp >= 500) begin nxt = 5; m_tmo = 1'b1; end
      end else if (m_st == 2) begin
        if (vbat >= 200) nxt = 3;
      end else if (m_st == 3) begin
        if (m_low >= 4 || m_nsmp >= 1000) nxt = 4;
      end else if (m_st == 4) begin
        if (vbat < 190) nxt = (vbat >= 150) ? 2 : 1;
      end else if (m_st == 5) begin
        if (!m_tmo && int'(vtemp) <= 92) nxt = 0;
      end
    end
    if (!rstz || nxt != m_st) begin
      m_nsmp = 0;
      m_low  = 0;
    end
    if (!rstz || nxt == 0) m_tmo = 1'b0;
    m_st  = nxt;
    m_sel = rstz ? int'(sel) : 0;
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    int e_iref;
    if (chk_en) begin
      e_iref = (m_st == 1) ? m_sel * 2 : (m_st == 2 || m_st == 3) ? m_sel * 16 : 0;
      n_chk++;
      if (int'(state) != m_st || tc != (m_st == 1) || cc != (m_st == 2) ||
          cv != (m_st == 3) || done != (m_st == 4) || fault != (m_st == 5) ||
          int'(iref) != e_iref) begin
        n_fail++;
        $display("FAIL cycle_check t=%0t: dut state=%0d tc=%0b cc=%0b cv=%0b done=%0b fault=%0b iref=%0d, model state=%0d iref=%0d",
                 $time, state, tc, cc, cv, done, fault, iref, m_st, e_iref);
      end
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Hold the given inputs across n active edges, returning 1 time unit after the last.
  task automatic cyc(input bit v, input logic [7:0] vb, input logic [7:0] ib,
                     input logic [7:0] vt, input int n = 1);
    for (int i = 0; i < n; i++) begin
      adc_valid = v; vbat = vb; ibat = ib; vtemp = vt;
      @(posedge clk); #1;
    end
    adc_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rstz = 1'b0; en = 1'b0; sel = 4'd0; adc_valid = 1'b0;
    vbat = 8'd0; ibat = 8'd0; vtemp = 8'd50;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 1'b1;
    chk("reset_state", int'(state), 0);
    chk("reset_iref", int'(iref), 0);
    chk("reset_flags", int'({tc, cc, cv, done, fault}), 0);

    // Trickle start and hand-over to CC
    rstz = 1'b1; en = 1'b1; sel = 4'b1010;
    cyc(1, 120, 0, 50);
    chk("tc_state", int'(state), 1);
    chk("tc_flag", int'(tc), 1);
    chk("tc_iref", int'(iref), 20);
    chk("model_tc", m_st, 1);
    cyc(1, 160, 0, 50);
    chk("cc_state", int'(state), 2);
    chk("cc_iref", int'(iref), 160);

    // CV and termination, including the 3-then-1 pattern
    cyc(1, 205, 50, 50);
    chk("cv_state", int'(state), 3);
    chk("cv_iref", int'(iref), 160);
    cyc(1, 205, 5, 50, 3);
    cyc(1, 205, 20, 50);
    chk("cv_no_term_3_1", int'(state), 3);
    cyc(1, 205, 5, 50, 3);
    chk("cv_after_3_low", int'(state), 3);
    cyc(1, 205, 5, 50);
    chk("done_flag", int'(done), 1);
    chk("done_iref", int'(iref), 0);
    chk("model_done", m_st, 4);

    // Recharge, over-temperature and hysteresis
    cyc(1, 185, 50, 50);
    chk("recharge_cc", int'(state), 2);
    cyc(1, 185, 50, 101);
    chk("overtemp_fault", int'(state), 5);
    chk("overtemp_iref", int'(iref), 0);
    cyc(1, 185, 50, 95);
    chk("fault_hold_95", int'(state), 5);
    cyc(1, 185, 50, 92);
    chk("fault_exit_92", int'(state), 0);

    // TC timeout: sticky until en drops
    cyc(1, 100, 0, 50);
    cyc(1, 100, 0, 50, 499);
    chk("tc_499", int'(state), 1);
    cyc(1, 100, 0, 50);
    chk("tc_timeout", int'(state), 5);
    chk("model_tc_timeout", m_st, 5);
    cyc(1, 100, 0, 50, 5);
    chk("tmo_sticky", int'(state), 5);
    en = 1'b0;
    cyc(0, 100, 0, 50);
    chk("tmo_en_off", int'(state), 0);
    en = 1'b1;

    // CV timeout
    cyc(1, 205, 50, 50);
    cyc(1, 205, 50, 50, 999);
    chk("cv_999", int'(state), 3);
    cyc(1, 205, 50, 50);
    chk("cv_timeout_done", int'(state), 4);

    // DONE to TC, then CC, sel change, en drop with simultaneous hot sample
    cyc(1, 100, 50, 50);
    chk("done_to_tc", int'(state), 1);
    cyc(1, 160, 50, 50);
    chk("tc_to_cc", int'(state), 2);
    sel = 4'd3;
    cyc(0, 160, 50, 50);
    chk("sel_change_iref", int'(iref), 48);
    sel = 4'b1010;
    en = 1'b0;
    cyc(1, 160, 50, 120);
    chk("en_off_beats_fault", int'(state), 0);
    chk("en_off_iref", int'(iref), 0);
    en = 1'b1;

    // Over-temperature together with vbat>=VCV in CC
    cyc(1, 160, 50, 50);
    cyc(1, 210, 50, 101);
    chk("cc_hot_vs_cv", int'(state), 5);
    cyc(1, 210, 50, 90);

    // Mid-charge reset
    cyc(1, 160, 50, 50);
    rstz = 1'b0;
    cyc(0, 160, 50, 50);
    chk("midreset_state", int'(state), 0);
    chk("midreset_out", int'({tc, cc, cv, done, fault, iref}), 0);
    rstz = 1'b1;

    // sel=0 keeps IDLE
    sel = 4'd0;
    cyc(1, 120, 0, 50, 5);
    chk("sel0_idle", int'(state), 0);
    chk("sel0_iref", int'(iref), 0);
    sel = 4'b1010;

    // Termination and timeout on the same sample
    cyc(1, 205, 50, 50);
    cyc(1, 205, 50, 50, 996);
    cyc(1, 205, 5, 50, 3);
    chk("cv_before_both", int'(state), 3);
    cyc(1, 205, 5, 50);
    chk("term_and_timeout", int'(state), 4);

    // Randomized traffic
    for (int i = 0; i < 4000; i++) begin
      rstz = ($urandom_range(0, 299) != 0);
      en   = ($urandom_range(0, 59) != 0);
      if ($urandom_range(0, 39) == 0) sel = 4'($urandom);
      cyc(1'($urandom_range(0, 1)), 8'($urandom_range(100, 230)),
          8'($urandom_range(0, 20)), 8'($urandom_range(60, 110)));
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
